// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command bytes and
// the microsecond-to-cycle helper used to size the line timers.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;

    // Multiply before dividing so fractional MHz clocks keep their precision;
    // 64-bit math because Hz x us overflows 32 bits for the watchdog.
    function automatic int ps2_us_to_cycles(input longint hz, input longint us);
        return int'((hz * us) / 64'sd1000000);
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for a raw PS/2 line plus a falling-edge strobe.
// Flops reset to 1 because an idle open-drain PS/2 line reads high.
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic synced,
    output logic fe
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain and one-cycle history for edge detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign synced = sync_q;
    assign fe     = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter, open-drain outputs (oe=1 pulls low).
// Optional watchdog over the device-clocked part of the frame is built in
// when PS2_HOST_TX_TIMEOUT_EN is defined; otherwise the block waits forever.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 3250000,
    parameter int INHIBIT_US  = 100,
    parameter int RTS_US      = 10,
    parameter int TIMEOUT_US  = 15000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int INH_CYC = ps2_us_to_cycles(longint'(CLK_FREQ_HZ), longint'(INHIBIT_US));
    localparam int RTS_CYC = ps2_us_to_cycles(longint'(CLK_FREQ_HZ), longint'(RTS_US));
    localparam int TO_CYC  = ps2_us_to_cycles(longint'(CLK_FREQ_HZ), longint'(TIMEOUT_US));
    localparam int TW      = $clog2(TO_CYC + 1);

    logic clk_synced;
    logic clk_fe;
    logic data_meta_q;
    logic data_synced_q;

    ps2_line_sync u_clk_sync (
        .clk     (clk),
        .reset   (reset),
        .line_in (ps2_clk_in),
        .synced  (clk_synced),
        .fe      (clk_fe)
    );

    // Data line only needs a synchronized level, never an edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_meta_q   <= 1'b1;
            data_synced_q <= 1'b1;
        end else begin
            data_meta_q   <= ps2_data_in;
            data_synced_q <= data_meta_q;
        end
    end

    ps2_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    idx_q, idx_d;
    logic          parity_q, parity_d;
    logic          err_q, err_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    // Next-state and registered-output logic for the whole frame.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        parity_d  = parity_q;
        err_d     = err_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = error_q;

        case (state_q)
            ST_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
                if (tx_valid && ready_q) begin
                    shift_d  = tx_data;
                    parity_d = ~^tx_data;
                    err_d    = 1'b0;
                    timer_d  = '0;
                    clk_oe_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (timer_q == TW'(INH_CYC - 1)) begin
                    timer_d   = '0;
                    data_oe_d = 1'b1;   // start bit doubles as request-to-send
                    state_d   = ST_RTS;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_RTS: begin
                if (timer_q == TW'(RTS_CYC - 1)) begin
                    timer_d  = '0;      // watchdog measures from here
                    clk_oe_d = 1'b0;
                    idx_d    = 3'd0;
                    state_d  = ST_DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_DATA: begin
                if (clk_fe) begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    idx_d     = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (clk_fe) begin
                    data_oe_d = ~parity_q;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (clk_fe) begin
                    data_oe_d = 1'b0;
                    state_d   = ST_ACK;
                end
            end
            ST_ACK: begin
                if (clk_fe) begin
                    err_d   = data_synced_q;   // device must pull data low to ACK
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_synced && data_synced_q) begin
                    done_d  = 1'b1;
                    error_d = err_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
        // Watchdog overrides everything, including a completion on the same cycle.
        if (state_q inside {ST_DATA, ST_PARITY, ST_STOP, ST_ACK, ST_WAIT_IDLE}) begin
            if (timer_q == TW'(TO_CYC - 1)) begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                done_d    = 1'b1;
                error_d   = 1'b1;
                state_d   = ST_IDLE;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
`endif

        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset releases both lines immediately.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            shift_q   <= 8'h00;
            idx_q     <= 3'd0;
            parity_q  <= 1'b0;
            err_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            parity_q  <= parity_d;
            err_q     <= err_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign tx_ready    = ready_q;
    assign busy        = busy_q;
    assign tx_done     = done_q;
    assign tx_error    = error_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host,
// records the bits it sees on each falling clock edge and optionally ACKs.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, busy;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int n_vec = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int acc_cnt = 0;

    ps2_host_tx dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .busy        (busy),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    // Open-drain wired-AND of host and device on each line.
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tx_done) done_cnt <= done_cnt + 1;
        if (reset && tx_valid && tx_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Reference frame as the device sees it: start, 8 data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f = '0;
        for (int i = 0; i < 8; i++) begin
            ones += int'(b[i]);
            f[i + 1] = b[i];
        end
        f[0]  = 1'b0;
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Device: waits for the host to release the clock, then produces 11 clocks.
    task automatic device_frame(input bit give_ack, input int half,
                                output logic [10:0] seen, output bit ok);
        int t;
        t = 0;
        ok = 1'b0;
        seen = '0;
        while (!(ps2_data_oe && !ps2_clk_oe) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) return;
        repeat (20) @(negedge clk);
        for (int k = 0; k < 11; k++) begin
            seen[k] = ps2_data_in;
            dev_clk_low = 1'b1;
            if (k == 10 && give_ack) dev_data_low = 1'b1;
            repeat (half) @(negedge clk);
            dev_clk_low  = 1'b0;
            dev_data_low = 1'b0;
            repeat (half) @(negedge clk);
        end
        ok = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input bit ack, input logic [10:0] exp_frame,
                        input bit exp_err, input int half);
        logic [10:0] seen;
        bit dev_ok;
        int inh, rts, t, gaps;
        inh = 0; rts = 0; t = 0; gaps = 0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        check($sformatf("accept_clk_oe_%02h", b), 32'(ps2_clk_oe), 1);
        check($sformatf("accept_busy_%02h", b), 32'(busy), 1);
        fork
            device_frame(ack, half, seen, dev_ok);
            begin
                @(negedge clk);
                while (ps2_clk_oe && !ps2_data_oe && inh < 1000) begin inh++; @(negedge clk); end
                while (ps2_clk_oe && ps2_data_oe && rts < 1000) begin rts++; @(negedge clk); end
                while (!tx_done && t < 20000) begin
                    if (!busy) gaps++;
                    @(negedge clk);
                    t++;
                end
                check($sformatf("inhibit_len_%02h", b), inh, 325);
                check($sformatf("rts_len_%02h", b), rts, 32);
                check($sformatf("done_%02h", b), 32'(tx_done), 1);
                check($sformatf("error_%02h", b), 32'(tx_error), 32'(exp_err));
                check($sformatf("lines_released_%02h", b), {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
                check($sformatf("busy_gap_%02h", b), gaps, 0);
                @(negedge clk);
                check($sformatf("busy_after_%02h", b), {30'd0, busy, tx_done}, 0);
            end
        join
        check($sformatf("frame_%02h", b), {20'd0, dev_ok, seen}, {20'd0, 1'b1, exp_frame});
    endtask

    typedef struct {
        logic [7:0]  data;
        bit          ack;
        logic [10:0] frame;
        bit          err;
    } vec_t;

    initial begin
        vec_t tbl[5];
        logic [7:0] bb[3];
        logic [10:0] fr[3];
        bit ok[3];
        int t, acc0, done0;

        tbl[0] = '{PS2_CMD_SET_LEDS, 1'b1, {2'b11, 8'hED, 1'b0}, 1'b0};
        tbl[1] = '{PS2_CMD_ENABLE,   1'b1, {2'b10, 8'hF4, 1'b0}, 1'b0};
        tbl[2] = '{8'h00,            1'b1, {2'b11, 8'h00, 1'b0}, 1'b0};
        tbl[3] = '{PS2_CMD_RESET,    1'b0, {2'b11, 8'hFF, 1'b0}, 1'b1};
        tbl[4] = '{PS2_ACK_BYTE,     1'b1, {2'b11, 8'hFA, 1'b0}, 1'b0};

        // Reset state, observed while reset is held.
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(tx_ready), 1);
        check("rst_busy_done_err", {29'd0, busy, tx_done, tx_error}, 0);
        check("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            send(tbl[i].data, tbl[i].ack, tbl[i].frame, tbl[i].err, 130);
        end

        for (int i = 0; i < 4; i++) begin
            logic [7:0] rb;
            bit rack;
            rb   = 8'($urandom_range(0, 255));
            rack = ($urandom_range(0, 3) != 0);
            send(rb, rack, frame_of(rb), !rack, $urandom_range(20, 60));
        end

        // Reset in the middle of the data phase.
        @(negedge clk);
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        t = 0;
        while (!(ps2_data_oe && !ps2_clk_oe) && t < 2000) begin @(negedge clk); t++; end
        done0 = done_cnt;
        for (int k = 0; k < 5; k++) begin
            dev_clk_low = 1'b1;
            repeat (40) @(negedge clk);
            if (k < 4) begin
                dev_clk_low = 1'b0;
                repeat (40) @(negedge clk);
            end
        end
        check("mid_data_oe", 32'(ps2_data_oe), 1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        check("mid_rst_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        dev_clk_low = 1'b0;
        reset = 1'b1;
        repeat (400) @(negedge clk);
        check("mid_rst_no_done", done_cnt - done0, 0);
        send(PS2_CMD_RESET, 1'b1, frame_of(PS2_CMD_RESET), 1'b0, 130);

        // tx_valid held high across three frames.
        bb[0] = 8'h3C; bb[1] = 8'hC1; bb[2] = 8'h5E;
        acc0 = acc_cnt;
        fork
            begin
                for (int i = 0; i < 3; i++) device_frame(1'b1, 40, fr[i], ok[i]);
            end
            begin
                @(negedge clk);
                tx_valid = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    int gaps;
                    gaps = 0;
                    tx_data = bb[i];
                    t = 0;
                    while (!tx_ready && t < 20000) begin @(negedge clk); t++; end
                    @(posedge clk);
                    #1;
                    check($sformatf("b2b_busy_%0d", i), 32'(busy), 1);
                    check($sformatf("b2b_ready_low_%0d", i), 32'(tx_ready), 0);
                    t = 0;
                    while (!tx_done && t < 20000) begin
                        @(negedge clk);
                        if (!busy) gaps++;
                        t++;
                    end
                    check($sformatf("b2b_done_%0d", i), {30'd0, tx_done, tx_error}, 2);
                    check($sformatf("b2b_gap_%0d", i), gaps, 0);
                end
                tx_valid = 1'b0;
            end
        join
        check("b2b_accepts", acc_cnt - acc0, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b2b_frame_%0d", i), {20'd0, ok[i], fr[i]}, {20'd0, 1'b1, frame_of(bb[i])});
        end

`ifdef PS2_HOST_TX_TIMEOUT_EN
        // Silent device: watchdog ends the frame a fixed time after clock release.
        repeat (5) @(negedge clk);
        tx_data  = PS2_CMD_ENABLE;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        t = 0;
        while (ps2_clk_oe && t < 2000) begin @(negedge clk); t++; end
        t = 0;
        while (!tx_done && t < 60000) begin @(negedge clk); t++; end
        check("timeout_cycles", t, 48750);
        check("timeout_error", 32'(tx_error), 1);
        check("timeout_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
`endif

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter that sends one command byte to the keyboard, for example 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable). It sits beside the existing `ps2` receiver on the same PS/2 lines (USB D+/D- in PS/2 mode, or the gpio pins) and drives them open-drain. `busy` tells the top level to discard receiver output while a transmission is in progress.

## Interface
Parameters:
- CLK_FREQ_HZ, 3250000, frequency of `clk` (the CPU clock).
- INHIBIT_US, 100, time `ps2_clk` is held low before request-to-send.
- RTS_US, 10, time data and clock are both held low before the clock is released.
- TIMEOUT_US, 15000, watchdog limit for the whole transfer.

Ports:
- clk  in  1  system clock; every flop is on its rising edge.
- reset  in  1  synchronous, active-low reset.
- tx_data  in  8  command byte; sampled on accept.
- tx_valid  in  1  request to send.
- tx_ready  out  1  high only in IDLE; accept = tx_valid & tx_ready.
- tx_done  out  1  one-cycle pulse when the transfer ends.
- tx_error  out  1  valid with tx_done; 1 = no ACK or timeout.
- busy  out  1  high from accept through the tx_done cycle.
- ps2_clk_in  in  1  raw PS/2 clock line, asynchronous.
- ps2_data_in  in  1  raw PS/2 data line, asynchronous.
- ps2_clk_oe  out  1  1 pulls the clock line low; the pad is open-drain.
- ps2_data_oe  out  1  1 pulls the data line low.

## Operation
- Both line inputs pass through a 2-flop synchronizer. A falling edge (`fe`) is registered synced-previous=1 and synced=0.
- Derived constants (cycles = CLK_FREQ_HZ/1_000_000 × µs):
  - INH_CYC = 325
  - RTS_CYC = 32
  - TO_CYC = 48750
  - A single timer counter, width $clog2(TO_CYC+1).
- States:
  - IDLE: tx_ready=1, both oe=0. On accept, latch tx_data, compute parity = ~^tx_data (odd parity), go to INHIBIT.
  - INHIBIT: clk_oe=1 for INH_CYC cycles, then RTS.
  - RTS: clk_oe=1 and data_oe=1 (this is the start bit) for RTS_CYC cycles, then release clk_oe and go to DATA with bit index 0.
  - DATA: on each `fe`, data_oe = ~shift[0], then shift right and increment the index. After the 8th `fe`, go to PARITY.
  - PARITY: on `fe`, data_oe = ~parity, go to STOP.
  - STOP: on `fe`, data_oe=0 (stop bit = 1, line released), go to ACK.
  - ACK: on `fe`, sample synced data. 0 = ACK ok, 1 = error. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until both synced lines are 1, then pulse tx_done with tx_error = stored error flag, and return to IDLE.
- The timeout timer counts from leaving RTS. Reaching TO_CYC in DATA..WAIT_IDLE forces both oe=0, tx_done=1, tx_error=1, next state IDLE.
- Accepting while the device is mid-frame is legal. The inhibit aborts the device frame and the device retransmits afterwards; the block takes no special action.
- tx_valid while busy is ignored (tx_ready=0). tx_data is don't-care outside accept.

## Timing
- Reset values: state IDLE, tx_ready=1, busy=0, tx_done=0, tx_error=0, ps2_clk_oe=0, ps2_data_oe=0, timer=0.
- Asserting reset mid-transfer releases both lines on that same clock edge. No tx_done is produced.
- Accept at edge N: ps2_clk_oe=1 and busy=1 from N+1.
- ps2_data_oe rises INH_CYC cycles after ps2_clk_oe rises.
- ps2_clk_oe falls RTS_CYC cycles after ps2_data_oe rises.
- Latency from a raw line falling edge to the data_oe change is 3 clk cycles (2 sync flops + edge register). This is well inside the device clock low phase (≥30 µs).
- tx_done is high exactly one cycle, the cycle after the lines are seen idle. busy falls in the cycle after tx_done. tx_ready returns with IDLE.
- If a timeout and a legitimate completion happen in the same cycle, the timeout wins (tx_error=1).

## Configuration
- PS2_HOST_TX_TIMEOUT_EN defined: the watchdog timer and timeout error path are built in.
- Not defined: no watchdog. The block waits indefinitely for device clocks, and tx_error reflects only a missing ACK.
- The INHIBIT and RTS timers exist either way.

## Structure
- Shared package `ps2_pkg`:
  - state enum (IDLE, INHIBIT, RTS, DATA, PARITY, STOP, ACK, WAIT_IDLE)
  - command constants PS2_CMD_RESET=8'hFF, PS2_CMD_SET_LEDS=8'hED, PS2_CMD_ENABLE=8'hF4
  - ACK byte 8'hFA
- One sub-module `ps2_line_sync`: 2-flop synchronizer plus falling-edge detect. It is instantiated for the clock line; the data line uses only its synced output.

## Test plan
- Send 0xED with a device model (12.5 kHz clock, ACK driven):
  - 325 cycles of clk_oe, then 32 cycles of clk_oe and data_oe together.
  - Device samples start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done=1 with tx_error=0.
- Send 0xF4 → parity bit 0. Send 0x00 → parity 1. Both complete without error.
- Device model withholds the ACK (data stays high on clock 11) → tx_done with tx_error=1.
- With PS2_HOST_TX_TIMEOUT_EN, device never clocks → tx_done with tx_error=1 exactly 48750 cycles after clk_oe falls; both oe=0.
- Reset driven low during DATA bit 4 → both oe=0 on the same edge, tx_done never pulses. The next send of 0xFF succeeds.
- tx_valid held high for 3 back-to-back bytes → each is accepted only while tx_ready=1, busy stays high across each frame, and the bytes are seen in order.
